// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit accumulator CPU sequencer:
// opcodes, ALU op encodings, sequencer states and default widths.
package cpu_pkg;

   localparam int unsigned ADDR_W_DEF = 4;
   localparam int unsigned DATA_W_DEF = 4;
   localparam int unsigned OPC_W      = 4;

   localparam logic [OPC_W-1:0] OP_HALT = 4'b0000;
   localparam logic [OPC_W-1:0] OP_LOAD = 4'b0001;
   localparam logic [OPC_W-1:0] OP_ADD  = 4'b0010;
   localparam logic [OPC_W-1:0] OP_SUB  = 4'b0011;
   localparam logic [OPC_W-1:0] OP_AND  = 4'b0100;
   localparam logic [OPC_W-1:0] OP_OR   = 4'b0101;
   localparam logic [OPC_W-1:0] OP_XOR  = 4'b0110;
   localparam logic [OPC_W-1:0] OP_XNOR = 4'b0111;
   localparam logic [OPC_W-1:0] OP_NOP  = 4'b1000;

   typedef enum logic [2:0] {
      ALU_ADD  = 3'b000,
      ALU_SUB  = 3'b001,
      ALU_AND  = 3'b010,
      ALU_OR   = 3'b011,
      ALU_XOR  = 3'b100,
      ALU_XNOR = 3'b101
   } alu_op_e;

   typedef enum logic [2:0] {
      S_IDLE, S_F_OP, S_F_ARG, S_DEC, S_EXEC, S_LD0, S_LD1, S_HALT
   } state_e;

   // States in which the core counts as running
   function automatic logic is_busy_state(input state_e s);
      return s inside {S_F_OP, S_F_ARG, S_DEC, S_EXEC, S_LD0, S_LD1};
   endfunction

endpackage

// File: rtl/cpu_decode.sv
// Combinational opcode decoder: latched opcode -> ALU op and instruction class.
module cpu_decode
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic [DATA_W-1:0] ir,
   output alu_op_e           alu_op,
   output logic              is_load,
   output logic              is_halt,
   output logic              is_nop,
   output logic              illegal
);

   always_comb begin
      alu_op  = ALU_ADD;
      is_load = 1'b0;
      is_halt = 1'b0;
      is_nop  = 1'b0;
      illegal = 1'b0;
      case (ir)
         DATA_W'(OP_HALT): is_halt = 1'b1;
         DATA_W'(OP_LOAD): is_load = 1'b1;
         DATA_W'(OP_ADD):  alu_op  = ALU_ADD;
         DATA_W'(OP_SUB):  alu_op  = ALU_SUB;
         DATA_W'(OP_AND):  alu_op  = ALU_AND;
         DATA_W'(OP_OR):   alu_op  = ALU_OR;
         DATA_W'(OP_XOR):  alu_op  = ALU_XOR;
         DATA_W'(OP_XNOR): alu_op  = ALU_XNOR;
         DATA_W'(OP_NOP):  is_nop  = 1'b1;
         default:          illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/cpu_seq.sv
// Multi-cycle fetch/decode/execute sequencer for the 4-bit accumulator CPU,
// sharing the IMEM write port with a host loader while the core is stopped.
module cpu_seq
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   output logic              busy,
   output logic              halted,
   output logic              err,
   output logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] ir,
   output logic [DATA_W-1:0] operand,
   output logic [ADDR_W-1:0] imem_addr,
   output logic              imem_re,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              imem_we,
   output logic [DATA_W-1:0] imem_wdata,
   input  logic              host_valid,
   output logic              host_ready,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_data,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic              dmem_re,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic [2:0]        alu_op,
   output logic              acc_we,
   output logic              r0_we,
   output logic              r1_we
);

   state_e  state_q, state_d;
   logic    stop_pend_q;
   logic    stop_now;
   logic    host_wr;
   logic    launch;
   alu_op_e dec_alu_op;
   logic    dec_load, dec_halt, dec_nop, dec_illegal;

   cpu_decode #(.DATA_W(DATA_W)) u_decode (
      .ir      (ir),
      .alu_op  (dec_alu_op),
      .is_load (dec_load),
      .is_halt (dec_halt),
      .is_nop  (dec_nop),
      .illegal (dec_illegal)
   );

   // A host write in the same cycle blocks start
   assign launch   = start && !host_valid;
   assign stop_now = stop_pend_q || stop;

   // Memory port muxing: host write passes straight through to IMEM
   assign host_wr    = host_valid && host_ready;
   assign imem_we    = host_wr;
   assign imem_wdata = host_data;
   assign imem_addr  = host_wr ? host_addr
                     : (state_q == S_F_ARG) ? pc + ADDR_W'(1) : pc;
   assign dmem_re    = ((state_q == S_DEC) && dec_load) || (state_q == S_LD0);
   assign dmem_addr  = (state_q == S_LD0) ? ADDR_W'(operand) + ADDR_W'(1)
                                         : ADDR_W'(imem_rdata);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_HALT: if (launch) state_d = S_F_OP;
         S_F_OP:  state_d = S_F_ARG;
         S_F_ARG: state_d = S_DEC;
         S_DEC: begin
            if (dec_halt || dec_illegal) state_d = S_HALT;
            else if (dec_nop)            state_d = stop_now ? S_HALT : S_F_OP;
            else if (dec_load)           state_d = S_LD0;
            else                         state_d = S_EXEC;
         end
         S_EXEC:  state_d = stop_now ? S_HALT : S_F_OP;
         S_LD0:   state_d = S_LD1;
         S_LD1:   state_d = stop_now ? S_HALT : S_F_OP;
         default: state_d = S_IDLE;
      endcase
   end

   // Strobes are registered from the next state so they line up with it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         stop_pend_q <= 1'b0;
         pc          <= '0;
         ir          <= '0;
         operand     <= '0;
         err         <= 1'b0;
         busy        <= 1'b0;
         halted      <= 1'b0;
         host_ready  <= 1'b0;
         imem_re     <= 1'b0;
         acc_we      <= 1'b0;
         r0_we       <= 1'b0;
         r1_we       <= 1'b0;
         alu_op      <= ALU_ADD;
      end else begin
         state_q    <= state_d;
         busy       <= is_busy_state(state_d);
         halted     <= (state_d == S_HALT);
         host_ready <= (state_d == S_IDLE) || (state_d == S_HALT);
         imem_re    <= (state_d == S_F_OP) || (state_d == S_F_ARG);
         acc_we     <= (state_d == S_EXEC);
         r0_we      <= (state_d == S_LD0);
         r1_we      <= (state_d == S_LD1);
         alu_op     <= (state_d == S_EXEC) ? dec_alu_op : ALU_ADD;

         if (state_d == S_HALT)
            stop_pend_q <= 1'b0;
         else if (is_busy_state(state_q) && stop)
            stop_pend_q <= 1'b1;

         case (state_q)
            S_IDLE, S_HALT: begin
               if (launch) begin
                  pc  <= '0;
                  err <= 1'b0;
               end
            end
            S_F_ARG: ir <= imem_rdata;
            S_DEC: begin
               operand <= imem_rdata;
               pc      <= pc + ADDR_W'(2);
               if (dec_illegal) err <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_seq.sv
// Directed self-checking bench for cpu_seq with behavioural IMEM/DMEM models.
module tb_cpu_seq;

   logic       clk = 1'b0;
   logic       reset, start, stop;
   logic       busy, halted, err;
   logic [3:0] pc, ir, operand;
   logic [3:0] imem_addr, imem_wdata, host_addr, host_data, dmem_addr;
   logic [3:0] imem_rdata = 4'h0;
   logic [3:0] dmem_rdata = 4'h0;
   logic       imem_re, imem_we, host_valid, host_ready, dmem_re;
   logic [2:0] alu_op;
   logic       acc_we, r0_we, r1_we;

   logic [3:0] imem [16] = '{default: 4'h0};
   logic [3:0] dmem [16];

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   cpu_seq dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop),
      .busy(busy), .halted(halted), .err(err),
      .pc(pc), .ir(ir), .operand(operand),
      .imem_addr(imem_addr), .imem_re(imem_re), .imem_rdata(imem_rdata),
      .imem_we(imem_we), .imem_wdata(imem_wdata),
      .host_valid(host_valid), .host_ready(host_ready),
      .host_addr(host_addr), .host_data(host_data),
      .dmem_addr(dmem_addr), .dmem_re(dmem_re), .dmem_rdata(dmem_rdata),
      .alu_op(alu_op), .acc_we(acc_we), .r0_we(r0_we), .r1_we(r1_we)
   );

   // Synchronous-read memories: data appears the cycle after the strobe
   always @(posedge clk) begin
      if (imem_we) imem[imem_addr] <= imem_wdata;
      if (imem_re) imem_rdata <= imem[imem_addr];
      if (dmem_re) dmem_rdata <= dmem[dmem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic hw(input logic [3:0] a, input logic [3:0] d);
      int n = 0;
      host_valid = 1'b1;
      host_addr  = a;
      host_data  = d;
      while (!host_ready && n < 50) begin
         tick();
         n++;
      end
      #1;
      chk("host_we", {31'd0, imem_we}, 32'd1);
      tick();
      host_valid = 1'b0;
   endtask

   task automatic wait_halt();
      int n = 0;
      while (!halted && n < 200) begin
         tick();
         n++;
      end
      chk("halt_wait", {31'd0, halted}, 32'd1);
   endtask

   task automatic go();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      int n_acc, n_r0, n_r1, bad;
      reset = 1'b0; start = 1'b0; stop = 1'b0;
      host_valid = 1'b0; host_addr = 4'h0; host_data = 4'h0;
      for (int i = 0; i < 16; i++) dmem[i] = 4'(i + 5);
      dmem[0] = 4'd4;
      dmem[1] = 4'd2;
      tick(); tick();

      // Reset state
      chk("rst_pc",     {28'd0, pc}, 32'd0);
      chk("rst_busy",   {31'd0, busy}, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_err",    {31'd0, err}, 32'd0);
      chk("rst_ready",  {31'd0, host_ready}, 32'd0);
      chk("rst_strobes", {27'd0, imem_re, imem_we, acc_we, r0_we, r1_we}, 32'd0);
      reset = 1'b1;
      tick();
      chk("idle_ready", {31'd0, host_ready}, 32'd1);

      // Program: LOAD 0; ADD 0; HALT 0
      hw(4'd0, 4'd1); hw(4'd1, 4'd0); hw(4'd2, 4'd2);
      hw(4'd3, 4'd0); hw(4'd4, 4'd0); hw(4'd5, 4'd0);
      go();
      n_acc = 0; n_r0 = 0; n_r1 = 0;
      for (int c = 1; c <= 13; c++) begin
         n_acc += int'(acc_we); n_r0 += int'(r0_we); n_r1 += int'(r1_we);
         if (c == 1) chk("p1_busy", {31'd0, busy}, 32'd1);
         if (c == 4) chk("p1_r0", {27'd0, r0_we, dmem_rdata}, 32'h14);
         if (c == 5) chk("p1_r1", {27'd0, r1_we, dmem_rdata}, 32'h12);
         if (c == 9) chk("p1_acc", {28'd0, acc_we, alu_op}, 32'h8);
         if (c != 13) tick();
      end
      chk("p1_halted", {31'd0, halted}, 32'd1);
      chk("p1_pc",     {28'd0, pc}, 32'd6);
      chk("p1_err",    {31'd0, err}, 32'd0);
      chk("p1_counts", 32'(n_acc * 100 + n_r0 * 10 + n_r1), 32'd111);

      // Host request while running waits for HALT
      go();
      tick();
      host_valid = 1'b1; host_addr = 4'd15; host_data = 4'd8;
      bad = 0;
      for (int c = 2; c <= 12; c++) begin
         #1;
         bad += int'(host_ready) + int'(imem_we);
         tick();
      end
      chk("busy_no_we", 32'(bad), 32'd0);
      #1;
      chk("halt_accept", {27'd0, halted, host_ready, imem_we, 2'b00}, 32'h1C);
      chk("halt_waddr", {28'd0, imem_addr}, 32'd15);
      tick();
      host_valid = 1'b0;
      chk("imem15", {28'd0, imem[15]}, 32'd8);

      // Illegal opcode
      hw(4'd0, 4'd9);
      go();
      n_acc = 0;
      for (int c = 1; c <= 4; c++) begin
         n_acc += int'(acc_we) + int'(r0_we) + int'(r1_we);
         if (c == 3) chk("ill_dec_halted", {31'd0, halted}, 32'd0);
         if (c != 4) tick();
      end
      chk("ill_err_halt", {30'd0, err, halted}, 32'd3);
      chk("ill_no_we", 32'(n_acc), 32'd0);
      go();
      chk("ill_err_clr", {30'd0, err, busy}, 32'd1);
      wait_halt();
      chk("ill_err_again", {31'd0, err}, 32'd1);
      hw(4'd0, 4'd1);

      // LOAD with stop during LD0
      go();
      tick(); tick(); tick();
      chk("ld_r0", {31'd0, r0_we}, 32'd1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("ld_r1", {31'd0, r1_we}, 32'd1);
      tick();
      chk("ld_halt", {26'd0, halted, busy, pc}, 32'h22);
      tick();
      chk("ld_no_fetch", {27'd0, imem_re, pc}, 32'h02);

      // Reset during EXEC
      hw(4'd0, 4'd2);
      go();
      tick(); tick(); tick();
      chk("ex_acc", {27'd0, acc_we, pc}, 32'h12);
      #2;
      reset = 1'b0;
      #1;
      chk("ex_rst", {26'd0, acc_we, busy, pc}, 32'h0);
      tick(); tick();
      reset = 1'b1;
      tick();
      go();
      chk("ex_restart", {26'd0, busy, imem_re, pc}, 32'h30);
      wait_halt();
      chk("ex_end_pc", {28'd0, pc}, 32'd6);

      // NOP sweep with wrap, then stop
      for (int a = 0; a < 16; a++) hw(4'(a), 4'd8);
      go();
      for (int c = 1; c <= 28; c++) begin
         if ((c - 1) % 3 == 0 && c <= 25)
            chk("nop_pc", {27'd0, busy, pc}, 32'(16 + ((c - 1) / 3 * 2) % 16));
         if (c == 25) stop = 1'b1;
         if (c == 26) stop = 1'b0;
         if (c == 27) chk("nop_pre_halt", {31'd0, halted}, 32'd0);
         if (c != 28) tick();
      end
      chk("nop_halt", {27'd0, halted, pc}, 32'h12);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
